vga_timing_sequencer: RTL and testbench

Run-time configurable VGA timing controller. It holds the active horizontal and vertical timing set, produces sync, blanking and pixel-position outputs, and accepts a new timing set through a config handshake. A new timing set is applied only at a frame boundary, so the display never sees a torn frame. It sits between the host/config logic and the pixel pipeline, in place of the fixed-threshold sync generators.

---
 rtl/vga_timing_sequencer.sv | 300 ++++++++++++++++++++++++++++++
 tb/tb_vga_timing_sequencer.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_sequencer.sv
// ----------------------------------------------------------------------------
// vga_timing_sequencer
//
// Run-time configurable VGA timing controller. Holds the active horizontal and
// vertical timing set, produces sync / blanking / pixel-position outputs, and
// accepts a replacement timing set through a small write + commit port. A
// validated replacement set only takes effect on a frame boundary (or when
// the generator is stopped), so the display never sees a torn frame.
//
// Ports:
//   control_clock      pixel clock, all logic on its rising edge
//   control_reset_n    asynchronous active-low reset
//   run_enable         1 = generate timing, 0 = stopped (counters held at 0)
//   cfg_valid/ready    shadow-set field write handshake
//   cfg_addr           field select (0..3 = H act/fp/sync/bp, 4..7 = V ...)
//   cfg_data           field value
//   cfg_commit         one-cycle request to apply the shadow set
//   cfg_error          one-cycle pulse when a commit fails validation
//   update_pending     a validated set is waiting for the frame boundary
//   counter_out_hsync  current x position
//   counter_out_vsync  current y position
//   h_sync, v_sync     sync outputs (level H_POL / V_POL while asserted)
//   display_enable     high inside the active picture region
//   frame_start        one-cycle pulse when the position is (0,0)
// ----------------------------------------------------------------------------
module vga_timing_sequencer #(
    parameter int COUNTER_SIZE = 11,
    parameter int H_ACTIVE_DEF = 1024,
    parameter int H_FP_DEF     = 24,
    parameter int H_SYNC_DEF   = 136,
    parameter int H_BP_DEF     = 184,
    parameter int V_ACTIVE_DEF = 768,
    parameter int V_FP_DEF     = 3,
    parameter int V_SYNC_DEF   = 6,
    parameter int V_BP_DEF     = 29,
    parameter bit H_POL        = 1'b0,
    parameter bit V_POL        = 1'b0
) (
    input  logic                    control_clock,
    input  logic                    control_reset_n,
    input  logic                    run_enable,
    input  logic                    cfg_valid,
    output logic                    cfg_ready,
    input  logic [2:0]              cfg_addr,
    input  logic [COUNTER_SIZE-1:0] cfg_data,
    input  logic                    cfg_commit,
    output logic                    cfg_error,
    output logic                    update_pending,
    output logic [COUNTER_SIZE-1:0] counter_out_hsync,
    output logic [COUNTER_SIZE-1:0] counter_out_vsync,
    output logic                    h_sync,
    output logic                    v_sync,
    output logic                    display_enable,
    output logic                    frame_start
);

    // Field positions inside a timing set; identical to the cfg_addr encoding.
    localparam int F_H_ACTIVE = 0;
    localparam int F_H_FP     = 1;
    localparam int F_H_SYNC   = 2;
    localparam int F_H_BP     = 3;
    localparam int F_V_ACTIVE = 4;
    localparam int F_V_FP     = 5;
    localparam int F_V_SYNC   = 6;
    localparam int F_V_BP     = 7;

    // Totals are carried two bits wider than a field so that an oversized
    // set is detected instead of silently wrapping.
    localparam logic [COUNTER_SIZE+1:0] MAX_TOTAL = {2'b00, {COUNTER_SIZE{1'b1}}};
    localparam logic [COUNTER_SIZE+1:0] TOTAL_ONE = {{(COUNTER_SIZE+1){1'b0}}, 1'b1};

    localparam logic [7:0][COUNTER_SIZE-1:0] DEF_SET = {
        COUNTER_SIZE'(V_BP_DEF),
        COUNTER_SIZE'(V_SYNC_DEF),
        COUNTER_SIZE'(V_FP_DEF),
        COUNTER_SIZE'(V_ACTIVE_DEF),
        COUNTER_SIZE'(H_BP_DEF),
        COUNTER_SIZE'(H_SYNC_DEF),
        COUNTER_SIZE'(H_FP_DEF),
        COUNTER_SIZE'(H_ACTIVE_DEF)
    };

    typedef enum logic [1:0] {
        ST_STOPPED = 2'd0,
        ST_RUNNING = 2'd1,
        ST_PENDING = 2'd2
    } state_t;

    function automatic logic [COUNTER_SIZE+1:0] sumFields(
        input logic [COUNTER_SIZE-1:0] a,
        input logic [COUNTER_SIZE-1:0] b,
        input logic [COUNTER_SIZE-1:0] c,
        input logic [COUNTER_SIZE-1:0] d
    );
        return {2'b00, a} + {2'b00, b} + {2'b00, c} + {2'b00, d};
    endfunction

    state_t                         r_state;
    logic [7:0][COUNTER_SIZE-1:0]   r_active;
    logic [7:0][COUNTER_SIZE-1:0]   r_shadow;
    logic [COUNTER_SIZE-1:0]        r_xCount;
    logic [COUNTER_SIZE-1:0]        r_yCount;
    logic                           r_hSync;
    logic                           r_vSync;
    logic                           r_displayEnable;
    logic                           r_frameStart;
    logic                           r_cfgError;
    logic                           r_pending;
    logic                           r_cfgReady;

    state_t                         w_stateNext;
    logic [7:0][COUNTER_SIZE-1:0]   w_activeNext;
    logic [7:0][COUNTER_SIZE-1:0]   w_shadowWr;
    logic [COUNTER_SIZE-1:0]        w_xNext;
    logic [COUNTER_SIZE-1:0]        w_yNext;
    logic [COUNTER_SIZE-1:0]        w_xAdv;
    logic [COUNTER_SIZE-1:0]        w_yAdv;
    logic                           w_allNonZero;
    logic                           w_setValid;
    logic                           w_commitSeen;
    logic                           w_commitOk;
    logic                           w_commitBad;
    logic                           w_lineEnd;
    logic                           w_frameEnd;
    logic [COUNTER_SIZE+1:0]        w_shadowHt;
    logic [COUNTER_SIZE+1:0]        w_shadowVt;
    logic [COUNTER_SIZE+1:0]        w_activeHt;
    logic [COUNTER_SIZE+1:0]        w_activeVt;
    logic                           w_runNext;
    logic [COUNTER_SIZE+1:0]        w_xWide;
    logic [COUNTER_SIZE+1:0]        w_yWide;
    logic [COUNTER_SIZE+1:0]        w_hsStart;
    logic [COUNTER_SIZE+1:0]        w_hsEnd;
    logic [COUNTER_SIZE+1:0]        w_vsStart;
    logic [COUNTER_SIZE+1:0]        w_vsEnd;
    logic                           w_hsOn;
    logic                           w_vsOn;
    logic                           w_deNext;
    logic                           w_fsNext;

    // A write offered in the same cycle as a commit lands first, so the
    // validated (and possibly applied) set is the shadow with the write merged.
    always_comb begin
        w_shadowWr = r_shadow;
        if (cfg_valid && r_cfgReady) begin
            w_shadowWr[cfg_addr] = cfg_data;
        end
    end

    always_comb begin
        w_allNonZero = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (w_shadowWr[i] == '0) begin
                w_allNonZero = 1'b0;
            end
        end
    end

    assign w_shadowHt = sumFields(w_shadowWr[F_H_ACTIVE], w_shadowWr[F_H_FP],
                                  w_shadowWr[F_H_SYNC], w_shadowWr[F_H_BP]);
    assign w_shadowVt = sumFields(w_shadowWr[F_V_ACTIVE], w_shadowWr[F_V_FP],
                                  w_shadowWr[F_V_SYNC], w_shadowWr[F_V_BP]);
    assign w_setValid = w_allNonZero && (w_shadowHt <= MAX_TOTAL) && (w_shadowVt <= MAX_TOTAL);

    // Commits that arrive while a set is already pending are dropped silently.
    assign w_commitSeen = cfg_commit && (r_state != ST_PENDING);
    assign w_commitOk   = w_commitSeen && w_setValid;
    assign w_commitBad  = w_commitSeen && !w_setValid;

    // Wrap points are judged against the set currently in force.
    assign w_activeHt = sumFields(r_active[F_H_ACTIVE], r_active[F_H_FP],
                                  r_active[F_H_SYNC], r_active[F_H_BP]);
    assign w_activeVt = sumFields(r_active[F_V_ACTIVE], r_active[F_V_FP],
                                  r_active[F_V_SYNC], r_active[F_V_BP]);
    assign w_lineEnd  = ({2'b00, r_xCount} == (w_activeHt - TOTAL_ONE));
    assign w_frameEnd = w_lineEnd && ({2'b00, r_yCount} == (w_activeVt - TOTAL_ONE));

    always_comb begin
        if (w_lineEnd) begin
            w_xAdv = '0;
            w_yAdv = w_frameEnd ? '0 : (r_yCount + COUNTER_SIZE'(1));
        end else begin
            w_xAdv = r_xCount + COUNTER_SIZE'(1);
            w_yAdv = r_yCount;
        end
    end

    // Stopping always flushes a pending set into the active set, so the next
    // start uses it; a valid commit that coincides with the stop is honoured too.
    always_comb begin
        w_stateNext  = r_state;
        w_activeNext = r_active;
        w_xNext      = r_xCount;
        w_yNext      = r_yCount;
        case (r_state)
            ST_STOPPED: begin
                w_xNext = '0;
                w_yNext = '0;
                if (w_commitOk) begin
                    w_activeNext = w_shadowWr;
                end
                if (run_enable) begin
                    w_stateNext = ST_RUNNING;
                end
            end
            ST_RUNNING: begin
                if (!run_enable) begin
                    w_stateNext = ST_STOPPED;
                    w_xNext     = '0;
                    w_yNext     = '0;
                    if (w_commitOk) begin
                        w_activeNext = w_shadowWr;
                    end
                end else begin
                    w_xNext = w_xAdv;
                    w_yNext = w_yAdv;
                    if (w_commitOk) begin
                        w_stateNext = ST_PENDING;
                    end
                end
            end
            ST_PENDING: begin
                if (!run_enable) begin
                    w_stateNext  = ST_STOPPED;
                    w_xNext      = '0;
                    w_yNext      = '0;
                    w_activeNext = r_shadow;
                end else begin
                    w_xNext = w_xAdv;
                    w_yNext = w_yAdv;
                    if (w_frameEnd) begin
                        w_activeNext = r_shadow;
                        w_stateNext  = ST_RUNNING;
                    end
                end
            end
            default: begin
                w_stateNext = ST_STOPPED;
                w_xNext     = '0;
                w_yNext     = '0;
            end
        endcase
    end

    // Output decode works on the next position and next active set so that
    // the registered outputs line up with the counter values they describe.
    assign w_runNext = (w_stateNext != ST_STOPPED);
    assign w_xWide   = {2'b00, w_xNext};
    assign w_yWide   = {2'b00, w_yNext};
    assign w_hsStart = {2'b00, w_activeNext[F_H_ACTIVE]} + {2'b00, w_activeNext[F_H_FP]};
    assign w_hsEnd   = w_hsStart + {2'b00, w_activeNext[F_H_SYNC]};
    assign w_vsStart = {2'b00, w_activeNext[F_V_ACTIVE]} + {2'b00, w_activeNext[F_V_FP]};
    assign w_vsEnd   = w_vsStart + {2'b00, w_activeNext[F_V_SYNC]};
    assign w_hsOn    = w_runNext && (w_xWide >= w_hsStart) && (w_xWide < w_hsEnd);
    assign w_vsOn    = w_runNext && (w_yWide >= w_vsStart) && (w_yWide < w_vsEnd);
    assign w_deNext  = w_runNext && (w_xNext < w_activeNext[F_H_ACTIVE])
                                 && (w_yNext < w_activeNext[F_V_ACTIVE]);
    assign w_fsNext  = w_runNext && (w_xNext == '0) && (w_yNext == '0);

    always_ff @(posedge control_clock or negedge control_reset_n) begin
        if (!control_reset_n) begin
            r_state         <= ST_STOPPED;
            r_active        <= DEF_SET;
            r_shadow        <= DEF_SET;
            r_xCount        <= '0;
            r_yCount        <= '0;
            r_hSync         <= ~H_POL;
            r_vSync         <= ~V_POL;
            r_displayEnable <= 1'b0;
            r_frameStart    <= 1'b0;
            r_cfgError      <= 1'b0;
            r_pending       <= 1'b0;
            r_cfgReady      <= 1'b1;
        end else begin
            r_state         <= w_stateNext;
            r_active        <= w_activeNext;
            r_shadow        <= w_shadowWr;
            r_xCount        <= w_xNext;
            r_yCount        <= w_yNext;
            r_hSync         <= w_hsOn ? H_POL : ~H_POL;
            r_vSync         <= w_vsOn ? V_POL : ~V_POL;
            r_displayEnable <= w_deNext;
            r_frameStart    <= w_fsNext;
            r_cfgError      <= w_commitBad;
            r_pending       <= (w_stateNext == ST_PENDING);
            r_cfgReady      <= (w_stateNext != ST_PENDING);
        end
    end

    assign cfg_ready         = r_cfgReady;
    assign cfg_error         = r_cfgError;
    assign update_pending    = r_pending;
    assign counter_out_hsync = r_xCount;
    assign counter_out_vsync = r_yCount;
    assign h_sync            = r_hSync;
    assign v_sync            = r_vSync;
    assign display_enable    = r_displayEnable;
    assign frame_start       = r_frameStart;

endmodule

// File: tb/tb_vga_timing_sequencer.sv
// ----------------------------------------------------------------------------
// tb_vga_timing_sequencer
//
// Self-checking bench for vga_timing_sequencer. The DUT is built with small
// reset timing (HT = 15, VT = 9) so whole frames are short. A cycle model
// predicts every registered output; predictions are queued when stimulus is
// driven and compared one cycle later when the DUT presents them. Frame
// period, active-pixel count and error-pulse count are also measured from
// the DUT outputs and compared with hand-computed constants.
// ----------------------------------------------------------------------------
module tb_vga_timing_sequencer;

    localparam int CS = 11;
    localparam int HA = 8;
    localparam int HF = 2;
    localparam int HS = 3;
    localparam int HB = 2;
    localparam int VA = 5;
    localparam int VF = 1;
    localparam int VS = 2;
    localparam int VB = 1;
    localparam int MAX_TOTAL = (1 << CS) - 1;

    logic          control_clock   = 1'b0;
    logic          control_reset_n = 1'b1;
    logic          run_enable      = 1'b0;
    logic          cfg_valid       = 1'b0;
    logic [2:0]    cfg_addr        = 3'd0;
    logic [CS-1:0] cfg_data        = '0;
    logic          cfg_commit      = 1'b0;
    logic          cfg_ready;
    logic          cfg_error;
    logic          update_pending;
    logic [CS-1:0] counter_out_hsync;
    logic [CS-1:0] counter_out_vsync;
    logic          h_sync;
    logic          v_sync;
    logic          display_enable;
    logic          frame_start;

    vga_timing_sequencer #(
        .COUNTER_SIZE (CS),
        .H_ACTIVE_DEF (HA),
        .H_FP_DEF     (HF),
        .H_SYNC_DEF   (HS),
        .H_BP_DEF     (HB),
        .V_ACTIVE_DEF (VA),
        .V_FP_DEF     (VF),
        .V_SYNC_DEF   (VS),
        .V_BP_DEF     (VB),
        .H_POL        (1'b0),
        .V_POL        (1'b0)
    ) dut (
        .control_clock     (control_clock),
        .control_reset_n   (control_reset_n),
        .run_enable        (run_enable),
        .cfg_valid         (cfg_valid),
        .cfg_ready         (cfg_ready),
        .cfg_addr          (cfg_addr),
        .cfg_data          (cfg_data),
        .cfg_commit        (cfg_commit),
        .cfg_error         (cfg_error),
        .update_pending    (update_pending),
        .counter_out_hsync (counter_out_hsync),
        .counter_out_vsync (counter_out_vsync),
        .h_sync            (h_sync),
        .v_sync            (v_sync),
        .display_enable    (display_enable),
        .frame_start       (frame_start)
    );

    always #5 control_clock = ~control_clock;

    typedef struct {
        int x;
        int y;
        bit hs;
        bit vs;
        bit de;
        bit fs;
        bit err;
        bit pend;
        bit rdy;
    } exp_t;

    exp_t expQ[$];

    int assertionCount = 0;
    int failureCount   = 0;

    // Reference model state: 0 = stopped, 1 = running, 2 = pending.
    int mState;
    int mX;
    int mY;
    int mAct[8];
    int mShd[8];
    int defSet[8] = '{HA, HF, HS, HB, VA, VF, VS, VB};

    // Measurements taken from DUT outputs.
    int  cycleNum    = 0;
    int  lastFsCycle = -1;
    int  fsInterval  = 0;
    int  deCount     = 0;
    int  deFrame     = 0;
    int  errCount    = 0;
    bit  sawFs       = 0;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        assertionCount++;
        if (observed != expected) begin
            failureCount++;
            $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    function automatic int total4(input int a, input int b, input int c, input int d);
        return a + b + c + d;
    endfunction

    function automatic void modelReset();
        mState = 0;
        mX     = 0;
        mY     = 0;
        for (int i = 0; i < 8; i++) begin
            mAct[i] = defSet[i];
            mShd[i] = defSet[i];
        end
    endfunction

    function automatic void modelExpect(input bit err);
        exp_t e;
        bit   run;
        bit   hsAct;
        bit   vsAct;
        run   = (mState != 0);
        hsAct = run && (mX >= mAct[0] + mAct[1]) && (mX < mAct[0] + mAct[1] + mAct[2]);
        vsAct = run && (mY >= mAct[4] + mAct[5]) && (mY < mAct[4] + mAct[5] + mAct[6]);
        e.x    = mX;
        e.y    = mY;
        e.hs   = !hsAct;
        e.vs   = !vsAct;
        e.de   = run && (mX < mAct[0]) && (mY < mAct[4]);
        e.fs   = run && (mX == 0) && (mY == 0);
        e.err  = err;
        e.pend = (mState == 2);
        e.rdy  = (mState != 2);
        expQ.push_back(e);
    endfunction

    function automatic void modelAdvance(input bit lineEnd, input bit lastPix);
        if (lineEnd) begin
            mX = 0;
            mY = lastPix ? 0 : mY + 1;
        end else begin
            mX = mX + 1;
        end
    endfunction

    function automatic void modelStep(input bit run, input bit valid, input int addr,
                                      input int data, input bit commit);
        int shdNew[8];
        bit ok;
        bit err;
        bit lineEnd;
        bit lastPix;
        int ht;
        int vt;
        shdNew = mShd;
        if (valid && mState != 2) shdNew[addr] = data;
        ok = 1;
        for (int i = 0; i < 8; i++) if (shdNew[i] == 0) ok = 0;
        if (total4(shdNew[0], shdNew[1], shdNew[2], shdNew[3]) > MAX_TOTAL) ok = 0;
        if (total4(shdNew[4], shdNew[5], shdNew[6], shdNew[7]) > MAX_TOTAL) ok = 0;
        err     = commit && (mState != 2) && !ok;
        ht      = total4(mAct[0], mAct[1], mAct[2], mAct[3]);
        vt      = total4(mAct[4], mAct[5], mAct[6], mAct[7]);
        lineEnd = (mX == ht - 1);
        lastPix = lineEnd && (mY == vt - 1);
        case (mState)
            0: begin
                if (commit && ok) mAct = shdNew;
                mX = 0;
                mY = 0;
                if (run) mState = 1;
            end
            1: begin
                if (!run) begin
                    if (commit && ok) mAct = shdNew;
                    mState = 0;
                    mX = 0;
                    mY = 0;
                end else begin
                    modelAdvance(lineEnd, lastPix);
                    if (commit && ok) mState = 2;
                end
            end
            default: begin
                if (!run) begin
                    mAct   = mShd;
                    mState = 0;
                    mX = 0;
                    mY = 0;
                end else begin
                    modelAdvance(lineEnd, lastPix);
                    if (lastPix) begin
                        mAct   = mShd;
                        mState = 1;
                    end
                end
            end
        endcase
        mShd = shdNew;
        modelExpect(err);
    endfunction

    task automatic compareNext();
        exp_t e;
        if (expQ.size() == 0) begin
            checkOutput("queue_empty", 0, 1);
        end else begin
            e = expQ.pop_front();
            checkOutput($sformatf("x@%0d", cycleNum),       int'(counter_out_hsync), e.x);
            checkOutput($sformatf("y@%0d", cycleNum),       int'(counter_out_vsync), e.y);
            checkOutput($sformatf("h_sync@%0d", cycleNum),  int'(h_sync),            int'(e.hs));
            checkOutput($sformatf("v_sync@%0d", cycleNum),  int'(v_sync),            int'(e.vs));
            checkOutput($sformatf("de@%0d", cycleNum),      int'(display_enable),    int'(e.de));
            checkOutput($sformatf("fs@%0d", cycleNum),      int'(frame_start),       int'(e.fs));
            checkOutput($sformatf("err@%0d", cycleNum),     int'(cfg_error),         int'(e.err));
            checkOutput($sformatf("pending@%0d", cycleNum), int'(update_pending),    int'(e.pend));
            checkOutput($sformatf("ready@%0d", cycleNum),   int'(cfg_ready),         int'(e.rdy));
        end
    endtask

    // Drive one cycle of stimulus, predict, then compare after the edge.
    task automatic applyStimulus(input bit run, input bit valid, input int addr,
                                 input int data, input bit commit);
        run_enable = run;
        cfg_valid  = valid;
        cfg_addr   = 3'(addr);
        cfg_data   = CS'(data);
        cfg_commit = commit;
        modelStep(run, valid, addr, data, commit);
        @(posedge control_clock);
        #1;
        cfg_valid  = 1'b0;
        cfg_commit = 1'b0;
        cycleNum++;
        compareNext();
        if (cfg_error) errCount++;
        if (frame_start) begin
            if (lastFsCycle >= 0) begin
                fsInterval = cycleNum - lastFsCycle;
                deFrame    = deCount;
            end
            lastFsCycle = cycleNum;
            deCount     = display_enable ? 1 : 0;
            sawFs       = 1;
        end else if (display_enable) begin
            deCount++;
        end
    endtask

    task automatic runCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1, 0, 0, 0, 0);
    endtask

    task automatic waitFrameStart(input int maxCycles);
        sawFs = 0;
        for (int i = 0; i < maxCycles && !sawFs; i++) applyStimulus(1, 0, 0, 0, 0);
        if (!sawFs) checkOutput("fs_timeout", 0, 1);
    endtask

    task automatic doReset();
        control_reset_n = 1'b0;
        run_enable      = 1'b0;
        cfg_valid       = 1'b0;
        cfg_commit      = 1'b0;
        #2;
        modelReset();
        modelExpect(0);
        compareNext();
        @(posedge control_clock);
        #1;
        control_reset_n = 1'b1;
        lastFsCycle     = -1;
        deCount         = 0;
    endtask

    initial begin
        #1;
        $display("[TB] reset and idle");
        doReset();
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 0);

        $display("[TB] default timing");
        waitFrameStart(5);
        waitFrameStart(200);
        checkOutput("period_default", fsInterval, 135);
        waitFrameStart(200);
        checkOutput("de_default", deFrame, 40);

        $display("[TB] mid-frame commit of a new set");
        runCycles(20);
        applyStimulus(1, 1, 0, 6, 0);
        applyStimulus(1, 1, 1, 1, 0);
        applyStimulus(1, 1, 2, 2, 0);
        applyStimulus(1, 1, 3, 1, 0);
        applyStimulus(1, 1, 4, 4, 0);
        applyStimulus(1, 1, 5, 1, 0);
        applyStimulus(1, 1, 6, 1, 0);
        applyStimulus(1, 1, 7, 2, 0);
        applyStimulus(1, 0, 0, 0, 1);
        waitFrameStart(300);
        checkOutput("period_commit_frame", fsInterval, 135);
        waitFrameStart(300);
        checkOutput("period_new", fsInterval, 80);
        checkOutput("de_new", deFrame, 24);

        $display("[TB] rejected commits");
        errCount = 0;
        applyStimulus(1, 1, 2, 0, 1);
        applyStimulus(1, 1, 2, 2, 0);
        runCycles(3);
        checkOutput("err_pulses_hsync0", errCount, 1);
        errCount = 0;
        applyStimulus(1, 1, 0, 2044, 1);
        applyStimulus(1, 1, 0, 6, 0);
        runCycles(3);
        checkOutput("err_pulses_overflow", errCount, 1);
        waitFrameStart(200);
        checkOutput("period_after_err", fsInterval, 80);

        $display("[TB] stopped-state commits");
        errCount = 0;
        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(0, 1, 0, 2043, 1);
        runCycles(20);
        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(0, 1, 0, 6, 1);
        applyStimulus(0, 1, 4, 3, 1);
        checkOutput("err_pulses_boundary", errCount, 0);
        waitFrameStart(5);
        waitFrameStart(200);
        checkOutput("period_vact3", fsInterval, 70);
        checkOutput("de_vact3", deFrame, 18);

        $display("[TB] stop with update pending");
        runCycles(5);
        applyStimulus(1, 1, 1, 3, 0);
        applyStimulus(1, 0, 0, 0, 1);
        runCycles(2);
        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);
        waitFrameStart(5);
        waitFrameStart(200);
        checkOutput("period_after_stop", fsInterval, 84);
        checkOutput("de_after_stop", deFrame, 18);

        $display("[TB] reset mid-frame");
        runCycles(30);
        applyStimulus(1, 1, 0, 7, 0);
        doReset();
        waitFrameStart(5);
        waitFrameStart(200);
        checkOutput("period_after_reset", fsInterval, 135);
        checkOutput("de_after_reset", deFrame, 40);

        $display("End of test - %0d assertions evaluated, %0d failures", assertionCount, failureCount);
        $finish;
    end

endmodule
